// File: rtl/pc_fetch_unit.sv
// Program-counter register and single-outstanding instruction-fetch sequencer.
// Holds the fetched word until commit, then advances to Next_Address or faults on misalignment.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  // Reset value of Commit_Count; nonzero only to reach the wrap point quickly in simulation.
  parameter logic [31:0] COUNT_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Next_Address,
  input  logic        Commit,
  input  logic        Imem_Req_Ready,
  input  logic        Imem_Rsp_Valid,
  input  logic [31:0] Imem_Rsp_Data,
  output logic [31:0] Current_pc,
  output logic        Imem_Req_Valid,
  output logic [31:0] Imem_Addr,
  output logic [31:0] Instr,
  output logic        Instr_Valid,
  output logic        Misaligned_Fault,
  output logic [31:0] Commit_Count
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    fault_d = fault_q;
    case (state_q)
      S_REQ: begin
        if (Imem_Req_Ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Imem_Rsp_Valid) begin
          instr_d = Imem_Rsp_Data;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Commit) begin
          count_d = count_q + 32'd1;
          if (Next_Address[1:0] == 2'b00) begin
            pc_d    = Next_Address;
            state_d = S_REQ;
          end else begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      // Terminal until reset: no requests, commits ignored.
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      count_q <= COUNT_INIT;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  assign Current_pc       = pc_q;
  assign Imem_Addr        = pc_q;
  assign Imem_Req_Valid   = (state_q == S_REQ);
  assign Instr            = instr_q;
  assign Instr_Valid      = (state_q == S_HOLD);
  assign Misaligned_Fault = fault_q;
  assign Commit_Count     = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized fetch/commit traffic
// checked against a transaction-level model (expected PC, latched word, commit count, fault flag).
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC    = 32'h0000_0100;
  localparam logic [31:0] WRAP_INIT = 32'hFFFF_FFFE;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Next_Address = '0;
  logic        Commit = 1'b0;
  logic        Imem_Req_Ready = 1'b0;
  logic        Imem_Rsp_Valid = 1'b0;
  logic [31:0] Imem_Rsp_Data = '0;

  logic [31:0] Current_pc, Imem_Addr, Instr, Commit_Count;
  logic        Imem_Req_Valid, Instr_Valid, Misaligned_Fault;
  logic [31:0] w_pc, w_addr, w_instr, w_count;
  logic        w_req, w_ivalid, w_fault;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .Next_Address(Next_Address), .Commit(Commit),
    .Imem_Req_Ready(Imem_Req_Ready), .Imem_Rsp_Valid(Imem_Rsp_Valid),
    .Imem_Rsp_Data(Imem_Rsp_Data), .Current_pc(Current_pc), .Imem_Req_Valid(Imem_Req_Valid),
    .Imem_Addr(Imem_Addr), .Instr(Instr), .Instr_Valid(Instr_Valid),
    .Misaligned_Fault(Misaligned_Fault), .Commit_Count(Commit_Count)
  );

  // Twin instance with a preloaded counter so the wrap to zero happens after two commits.
  pc_fetch_unit #(.RESET_PC(RST_PC), .COUNT_INIT(WRAP_INIT)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .Next_Address(Next_Address), .Commit(Commit),
    .Imem_Req_Ready(Imem_Req_Ready), .Imem_Rsp_Valid(Imem_Rsp_Valid),
    .Imem_Rsp_Data(Imem_Rsp_Data), .Current_pc(w_pc), .Imem_Req_Valid(w_req),
    .Imem_Addr(w_addr), .Instr(w_instr), .Instr_Valid(w_ivalid),
    .Misaligned_Fault(w_fault), .Commit_Count(w_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_count;
  logic        m_fault;

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_count = 0; m_fault = 1'b0;
  endtask

  // Runs one fetch starting in the request phase; ends at a negedge with the word held.
  task automatic fetch_instr(input int ready_delay, input int rsp_delay, input logic [31:0] data,
                             input bit stray, output int acc_cyc);
    logic [31:0] rnd;
    for (int i = 0; i <= ready_delay; i++) begin
      checks++;
      if (Imem_Req_Valid !== 1'b1 || Imem_Addr !== m_pc || Current_pc !== m_pc) begin
        failures++;
        $display("FAIL fetch_req: req=%b addr=%h pc=%h, required req=1 addr=pc=%h",
                 Imem_Req_Valid, Imem_Addr, Current_pc, m_pc);
      end
      checks++;
      if (Instr_Valid !== 1'b0 || Instr !== m_instr) begin
        failures++;
        $display("FAIL fetch_req_instr: valid=%b instr=%h, required valid=0 instr=%h",
                 Instr_Valid, Instr, m_instr);
      end
      rnd = $urandom;
      Imem_Req_Ready = (i == ready_delay);
      Imem_Rsp_Valid = stray & rnd[0];
      Imem_Rsp_Data  = 32'hDEAD_BEEF;
      acc_cyc = cyc;
      @(negedge clk);
    end
    Imem_Req_Ready = 1'b0;
    for (int i = 0; i <= rsp_delay; i++) begin
      checks++;
      if (Imem_Req_Valid !== 1'b0 || Instr_Valid !== 1'b0 || Imem_Addr !== m_pc) begin
        failures++;
        $display("FAIL fetch_wait: req=%b valid=%b addr=%h, required req=0 valid=0 addr=%h",
                 Imem_Req_Valid, Instr_Valid, Imem_Addr, m_pc);
      end
      Imem_Rsp_Valid = (i == rsp_delay);
      Imem_Rsp_Data  = (i == rsp_delay) ? data : $urandom;
      @(negedge clk);
    end
    Imem_Rsp_Valid = 1'b0;
    m_instr = data;
    checks++;
    if (Instr_Valid !== 1'b1 || Instr !== m_instr) begin
      failures++;
      $display("FAIL fetch_rsp: valid=%b instr=%h, required valid=1 instr=%h",
               Instr_Valid, Instr, m_instr);
    end
  endtask

  // Holds the word for hold_cycles (with stray responses), then commits next.
  task automatic commit_instr(input logic [31:0] next, input int hold_cycles);
    for (int i = 0; i < hold_cycles; i++) begin
      Commit = 1'b0;
      Next_Address = $urandom;
      Imem_Rsp_Valid = 1'b1;
      Imem_Rsp_Data = $urandom;
      @(negedge clk);
      checks++;
      if (Instr_Valid !== 1'b1 || Instr !== m_instr || Current_pc !== m_pc) begin
        failures++;
        $display("FAIL hold: valid=%b instr=%h pc=%h, required valid=1 instr=%h pc=%h",
                 Instr_Valid, Instr, Current_pc, m_instr, m_pc);
      end
    end
    Imem_Rsp_Valid = 1'b0;
    Commit = 1'b1;
    Next_Address = next;
    m_count = m_count + 1;
    if (next[1:0] == 2'b00) m_pc = next;
    else m_fault = 1'b1;
    @(negedge clk);
    Commit = 1'b0;
    checks++;
    if (Instr_Valid !== 1'b0 || Current_pc !== m_pc || Misaligned_Fault !== m_fault) begin
      failures++;
      $display("FAIL commit: valid=%b pc=%h fault=%b, required valid=0 pc=%h fault=%b",
               Instr_Valid, Current_pc, Misaligned_Fault, m_pc, m_fault);
    end
    checks++;
    if (Commit_Count !== m_count || Imem_Req_Valid !== !m_fault) begin
      failures++;
      $display("FAIL commit_count: count=%0d req=%b, required count=%0d req=%b",
               Commit_Count, Imem_Req_Valid, m_count, !m_fault);
    end
    checks++;
    if (w_count !== WRAP_INIT + m_count) begin
      failures++;
      $display("FAIL count_wrap: count=%h, required %h", w_count, WRAP_INIT + m_count);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (Current_pc !== RST_PC || Imem_Addr !== RST_PC || Instr !== NOP) begin
      failures++;
      $display("FAIL %s_regs: pc=%h addr=%h instr=%h, required pc=addr=%h instr=%h",
               tag, Current_pc, Imem_Addr, Instr, RST_PC, NOP);
    end
    checks++;
    if (Instr_Valid !== 1'b0 || Imem_Req_Valid !== 1'b1 || Misaligned_Fault !== 1'b0 ||
        Commit_Count !== 32'd0 || w_count !== WRAP_INIT) begin
      failures++;
      $display("FAIL %s_flags: valid=%b req=%b fault=%b count=%h wcount=%h", tag,
               Instr_Valid, Imem_Req_Valid, Misaligned_Fault, Commit_Count, w_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
  endtask

  int acc_prev, acc_now;

  task automatic test_first_fetch();
    fetch_instr(0, 0, 32'h0050_0093, 1'b0, acc_prev);
    checks++;
    if (Imem_Addr !== 32'h0000_0100 || Instr !== 32'h0050_0093) begin
      failures++;
      $display("FAIL first_fetch: addr=%h instr=%h, required 00000100 00500093", Imem_Addr, Instr);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      commit_instr(m_pc + 32'd4, 0);
      fetch_instr(0, 0, $urandom, 1'b0, acc_now);
      checks++;
      if (acc_now - acc_prev !== 3) begin
        failures++;
        $display("FAIL seq_rate: %0d cycles per instruction, required 3", acc_now - acc_prev);
      end
      acc_prev = acc_now;
    end
    checks++;
    if (Current_pc !== 32'h0000_010C || Commit_Count !== 32'd3) begin
      failures++;
      $display("FAIL seq_end: pc=%h count=%0d, required 0000010c 3", Current_pc, Commit_Count);
    end
  endtask

  task automatic test_backpressure();
    commit_instr(m_pc + 32'd4, 1);
    fetch_instr(5, 0, 32'h0010_0113, 1'b1, acc_now);
  endtask

  task automatic test_random();
    logic [31:0] nxt;
    for (int k = 0; k < 20; k++) begin
      nxt = $urandom;
      nxt[1:0] = 2'b00;
      commit_instr(nxt, int'($urandom_range(3, 0)));
      fetch_instr(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom, 1'b1,
                  acc_now);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rnd;
    commit_instr(32'h0000_0202, 1);
    for (int i = 0; i < 6; i++) begin
      rnd = $urandom;
      Commit = rnd[0];
      Next_Address = m_pc + 32'd4;
      Imem_Req_Ready = 1'b1;
      Imem_Rsp_Valid = 1'b1;
      Imem_Rsp_Data = $urandom;
      @(negedge clk);
      checks++;
      if (Imem_Req_Valid !== 1'b0 || Instr_Valid !== 1'b0 || Misaligned_Fault !== 1'b1 ||
          Commit_Count !== m_count || Current_pc !== m_pc) begin
        failures++;
        $display("FAIL fault_hold: req=%b valid=%b fault=%b count=%0d pc=%h, required 0 0 1 %0d %h",
                 Imem_Req_Valid, Instr_Valid, Misaligned_Fault, Commit_Count, Current_pc,
                 m_count, m_pc);
      end
    end
    Commit = 1'b0; Imem_Req_Ready = 1'b0; Imem_Rsp_Valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Recover from the fault, then reach the wait phase of the second instruction.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    fetch_instr(0, 0, $urandom, 1'b0, acc_now);
    commit_instr(32'h0000_0400, 0);
    Imem_Req_Ready = 1'b1;
    @(negedge clk);
    Imem_Req_Ready = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_values("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    Imem_Rsp_Valid = 1'b1;
    Imem_Rsp_Data = 32'hCAFE_F00D;
    @(negedge clk);
    Imem_Rsp_Valid = 1'b0;
    checks++;
    if (Instr !== NOP || Instr_Valid !== 1'b0 || Imem_Req_Valid !== 1'b1 || Imem_Addr !== RST_PC)
    begin
      failures++;
      $display("FAIL late_rsp: instr=%h valid=%b req=%b addr=%h, required %h 0 1 %h",
               Instr, Instr_Valid, Imem_Req_Valid, Imem_Addr, NOP, RST_PC);
    end
    fetch_instr(1, 1, 32'h0000_0513, 1'b0, acc_now);
    commit_instr(RST_PC + 32'd4, 0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_backpressure();
    test_random();
    test_misaligned();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
